// File: rtl/binary_one_hot_pipe.sv
// Binary to one-hot / one-cold / thermometer decoder behind a 2-entry
// valid/ready FIFO, with a saturating count of accepted error beats.
module binary_one_hot_pipe #(
    parameter int BINARY  = 4,
    parameter int ONE_HOT = 16
) (
    input  logic               Clk_I,
    input  logic               Rst_I,
    input  logic               In_Valid_I,
    output logic               In_Ready_O,
    input  logic [BINARY-1:0]  Bin_I,
    input  logic [1:0]         Mode_I,
    output logic               Out_Valid_O,
    input  logic               Out_Ready_I,
    output logic [ONE_HOT-1:0] One_Hot_O,
    output logic               Range_Err_O,
    input  logic               Err_Clr_I,
    output logic [7:0]         Err_Count_O
);

    generate
        if (BINARY < 1 || BINARY > 8 ||
            ONE_HOT < 2 || ONE_HOT > (1 << BINARY)) begin : g_bad_param
            $error("binary_one_hot_pipe: illegal BINARY/ONE_HOT");
        end
    endgenerate

    logic [ONE_HOT-1:0] w_hot;
    logic [ONE_HOT-1:0] w_thr;
    logic [ONE_HOT-1:0] w_word;
    logic               w_oob;
    logic               w_err;
    logic               w_push;
    logic               w_pop;
    logic               w_acc_err;

    logic [1:0]         r_cnt;
    logic               r_en;
    logic [ONE_HOT-1:0] r_word0;
    logic [ONE_HOT-1:0] r_word1;
    logic               r_err0;
    logic               r_err1;
    logic [7:0]         r_err_cnt;

    always_comb begin
        w_hot = '0;
        w_thr = '0;
        for (int i = 0; i < ONE_HOT; i++) begin
            w_hot[i] = (i == int'(Bin_I));
            w_thr[i] = (i <= int'(Bin_I));
        end
    end

    // Out-of-range codes fall out naturally for one-hot/one-cold;
    // thermometer would saturate to all ones, so force it to zero.
    always_comb begin
        w_oob = (int'(Bin_I) >= ONE_HOT);
        case (Mode_I)
            2'b00:   w_word = w_hot;
            2'b01:   w_word = ~w_hot;
            2'b10:   w_word = w_oob ? '0 : w_thr;
            default: w_word = '0;
        endcase
        w_err = w_oob | (Mode_I == 2'b11);
    end

    assign In_Ready_O  = r_en & (r_cnt != 2'd2);
    assign Out_Valid_O = (r_cnt != 2'd0);
    assign One_Hot_O   = Out_Valid_O ? r_word0 : '0;
    assign Range_Err_O = Out_Valid_O & r_err0;
    assign Err_Count_O = r_err_cnt;

    assign w_push    = In_Valid_I & In_Ready_O;
    assign w_pop     = Out_Valid_O & Out_Ready_I;
    assign w_acc_err = w_push & w_err;

    // Slot 0 is always the head; push+pop only happens at occupancy 1.
    always_ff @(posedge Clk_I or posedge Rst_I) begin
        if (Rst_I) begin
            r_cnt   <= 2'd0;
            r_en    <= 1'b0;
            r_word0 <= '0;
            r_word1 <= '0;
            r_err0  <= 1'b0;
            r_err1  <= 1'b0;
        end else begin
            r_en <= 1'b1;
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) begin
                        r_word0 <= w_word;
                        r_err0  <= w_err;
                    end else begin
                        r_word1 <= w_word;
                        r_err1  <= w_err;
                    end
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_word0 <= r_word1;
                    r_err0  <= r_err1;
                    r_cnt   <= r_cnt - 2'd1;
                end
                2'b11: begin
                    r_word0 <= w_word;
                    r_err0  <= w_err;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk_I or posedge Rst_I) begin
        if (Rst_I) begin
            r_err_cnt <= 8'd0;
        end else if (Err_Clr_I) begin
            r_err_cnt <= w_acc_err ? 8'd1 : 8'd0;
        end else if (w_acc_err && r_err_cnt != 8'hFF) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_binary_one_hot_pipe.sv
// Directed-vector bench for binary_one_hot_pipe: default geometry plus
// a ONE_HOT=10 instance for the range-error cases.
module tb_binary_one_hot_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [3:0]  bin;
    logic [1:0]  mode;
    logic        out_ready;
    logic        err_clr;

    logic        in_ready;
    logic        out_valid;
    logic [15:0] one_hot;
    logic        range_err;
    logic [7:0]  err_count;

    logic        in_ready_t;
    logic        out_valid_t;
    logic [9:0]  one_hot_t;
    logic        range_err_t;
    logic [7:0]  err_count_t;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    binary_one_hot_pipe u_dut (
        .Clk_I       (clk),
        .Rst_I       (rst),
        .In_Valid_I  (in_valid),
        .In_Ready_O  (in_ready),
        .Bin_I       (bin),
        .Mode_I      (mode),
        .Out_Valid_O (out_valid),
        .Out_Ready_I (out_ready),
        .One_Hot_O   (one_hot),
        .Range_Err_O (range_err),
        .Err_Clr_I   (err_clr),
        .Err_Count_O (err_count)
    );

    binary_one_hot_pipe #(.BINARY(4), .ONE_HOT(10)) u_dut10 (
        .Clk_I       (clk),
        .Rst_I       (rst),
        .In_Valid_I  (in_valid),
        .In_Ready_O  (in_ready_t),
        .Bin_I       (bin),
        .Mode_I      (mode),
        .Out_Valid_O (out_valid_t),
        .Out_Ready_I (out_ready),
        .One_Hot_O   (one_hot_t),
        .Range_Err_O (range_err_t),
        .Err_Clr_I   (err_clr),
        .Err_Count_O (err_count_t)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] b, input logic [1:0] m);
        in_valid = 1'b1;
        bin      = b;
        mode     = m;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; bin = '0; mode = '0;
        out_ready = 1'b1; err_clr = 1'b0;
        #2;
        chk("rst_rdy",  in_ready,  0);
        chk("rst_vld",  out_valid, 0);
        chk("rst_word", one_hot,   0);
        chk("rst_rerr", range_err, 0);
        chk("rst_cnt",  err_count, 0);
        #10;
        rst = 1'b0;
        #1;
        chk("rel_rdy0", in_ready, 0);
        tick();
        chk("rel_rdy1", in_ready, 1);

        send(4'd5, 2'b00);
        chk("hot5_vld",  out_valid, 1);
        chk("hot5_word", one_hot,   32'h0020);
        chk("hot5_rerr", range_err, 0);
        send(4'd0, 2'b01);
        chk("cold0", one_hot, 32'hFFFE);
        send(4'd3, 2'b10);
        chk("thr3", one_hot, 32'h000F);
        send(4'd15, 2'b10);
        chk("thr15", one_hot, 32'hFFFF);
        send(4'd15, 2'b00);
        chk("hot15", one_hot, 32'h8000);
        tick();
        chk("empty_vld",  out_valid, 0);
        chk("empty_word", one_hot,   0);

        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clr_cnt10", err_count_t, 0);
        chk("clr_cnt16", err_count,   0);

        send(4'd12, 2'b00);
        chk("t_oob_word", one_hot_t,   0);
        chk("t_oob_rerr", range_err_t, 1);
        chk("t_oob_cnt",  err_count_t, 1);
        send(4'd2, 2'b11);
        chk("t_rsv_word", one_hot_t,   0);
        chk("t_rsv_rerr", range_err_t, 1);
        chk("t_rsv_cnt",  err_count_t, 2);
        chk("rsv_rerr16", range_err,   1);
        send(4'd12, 2'b01);
        chk("t_cold_oob", one_hot_t,   32'h3FF);
        chk("t_cold_cnt", err_count_t, 3);
        send(4'd9, 2'b00);
        chk("t_hot9",     one_hot_t,   32'h200);
        chk("t_hot9_err", range_err_t, 0);
        chk("cnt16",      err_count,   1);
        tick();

        out_ready = 1'b0;
        in_valid  = 1'b1; mode = 2'b00;
        bin = 4'd1;
        tick();
        chk("bp_rdy1", in_ready, 1);
        bin = 4'd2;
        tick();
        chk("bp_rdy2", in_ready, 0);
        chk("bp_head", one_hot,  32'h0002);
        bin = 4'd3;
        tick();
        chk("bp_hold", one_hot,  32'h0002);
        chk("bp_rdy3", in_ready, 0);
        out_ready = 1'b1;
        tick();
        chk("bp_out2", one_hot,  32'h0004);
        chk("bp_rdy4", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("bp_out3", one_hot, 32'h0008);
        tick();
        chk("bp_drain", out_valid, 0);

        in_valid = 1'b1; mode = 2'b11; bin = 4'd0;
        repeat (253) tick();
        chk("sat_254", err_count, 254);
        tick();
        chk("sat_255", err_count, 255);
        repeat (46) tick();
        chk("sat_300",   err_count,   255);
        chk("sat_t300",  err_count_t, 255);
        err_clr = 1'b1;
        tick();
        chk("clr_acc", err_count, 1);
        in_valid = 1'b0;
        tick();
        chk("clr_idle", err_count, 0);
        err_clr = 1'b0;
        tick();

        out_ready = 1'b0;
        send(4'd4, 2'b00);
        send(4'd6, 2'b00);
        chk("full_rdy",  in_ready, 0);
        chk("full_head", one_hot,  32'h0010);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_vld",  out_valid, 0);
        chk("ar_word", one_hot,   0);
        chk("ar_rerr", range_err, 0);
        chk("ar_rdy",  in_ready,  0);
        #2;
        rst = 1'b0;
        tick();
        chk("ar_rdy1", in_ready,  1);
        chk("ar_vld1", out_valid, 0);
        out_ready = 1'b1;
        tick();
        chk("ar_stale", out_valid, 0);
        send(4'd9, 2'b00);
        chk("ar_new", one_hot, 32'h0200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
